// File: rtl/cnn_pkg.sv
// Shared constants, window type and fetch FSM state encoding for the conv
// window fetch path.
package cnn_pkg;

  localparam int K      = 5;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 16;

  typedef logic [K*K*DATA_W-1:0] window_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    GAP,
    REQ,
    WAIT,
    PRESENT,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/conv_pos_counter.sv
// Output-map position tracker: row/col, the running address of the current
// window's top-left word, and last-position detection.
module conv_pos_counter #(
  parameter int K      = cnn_pkg::K,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DIM_W  = cnn_pkg::DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic [DIM_W-1:0]  i_stride,
  output logic [DIM_W-1:0]  o_row,
  output logic [DIM_W-1:0]  o_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  import cnn_pkg::*;

  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_ow;
  logic [DIM_W-1:0]  r_oh;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_col_off;
  logic [ADDR_W-1:0] r_col_step;
  logic [ADDR_W-1:0] r_row_step;

  logic [DIM_W-1:0]  w_ow;
  logic [DIM_W-1:0]  w_oh;
  logic [ADDR_W-1:0] w_row_step;
  logic              w_col_last;

  // i_stride is never zero here; the top substitutes 1 before latching.
  assign w_ow       = (i_img_w - DIM_W'(K)) / i_stride + DIM_W'(1);
  assign w_oh       = (i_img_h - DIM_W'(K)) / i_stride + DIM_W'(1);
  assign w_row_step = ADDR_W'(i_img_w) * ADDR_W'(i_stride);
  assign w_col_last = (r_col == r_ow - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_ow       <= '0;
      r_oh       <= '0;
      r_row_base <= '0;
      r_col_off  <= '0;
      r_col_step <= '0;
      r_row_step <= '0;
    end else if (i_init) begin
      r_row      <= '0;
      r_col      <= '0;
      r_ow       <= w_ow;
      r_oh       <= w_oh;
      r_row_base <= i_base;
      r_col_off  <= '0;
      r_col_step <= ADDR_W'(i_stride);
      r_row_step <= w_row_step;
    end else if (i_advance) begin
      // Column offset is accumulated so no per-window multiply is needed.
      if (w_col_last) begin
        r_col      <= '0;
        r_col_off  <= '0;
        r_row      <= r_row + DIM_W'(1);
        r_row_base <= r_row_base + r_row_step;
      end else begin
        r_col     <= r_col + DIM_W'(1);
        r_col_off <= r_col_off + r_col_step;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_addr = r_row_base + r_col_off;
  assign o_last = w_col_last && (r_row == r_oh - DIM_W'(1));

endmodule

// File: rtl/conv_window_fetch.sv
// Walks a row-major feature map, issues one 5x5 window read per output
// position and hands each captured window to the MAC stage via valid/ready.
module conv_window_fetch #(
  parameter int K      = cnn_pkg::K,
  parameter int ADDR_W = cnn_pkg::ADDR_W,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DIM_W  = cnn_pkg::DIM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [DIM_W-1:0]        img_w,
  input  logic [DIM_W-1:0]        img_h,
  input  logic [DIM_W-1:0]        stride,
  output logic                    mem_enable,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [ADDR_W-1:0]       mem_offset,
  input  logic                    mem_finish,
  input  logic [K*K*DATA_W-1:0]   mem_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic [DIM_W-1:0]        win_row,
  output logic [DIM_W-1:0]        win_col,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  import cnn_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [ADDR_W-1:0]     r_base;
  logic [DIM_W-1:0]      r_img_w;
  logic [DIM_W-1:0]      r_img_h;
  logic [DIM_W-1:0]      r_stride;
  logic                  r_err;
  logic                  r_wait_first;
  logic [K*K*DATA_W-1:0] r_win_data;
  logic [DIM_W-1:0]      r_win_row;
  logic [DIM_W-1:0]      r_win_col;

  logic              w_init;
  logic              w_advance;
  logic              w_capture;
  logic              w_dims_bad;
  logic              w_last;
  logic [DIM_W-1:0]  w_row;
  logic [DIM_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_addr;

  conv_pos_counter #(
    .K      (K),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .i_init    (w_init),
    .i_advance (w_advance),
    .i_base    (r_base),
    .i_img_w   (r_img_w),
    .i_img_h   (r_img_h),
    .i_stride  (r_stride),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  assign w_dims_bad = (r_img_w < DIM_W'(K)) || (r_img_h < DIM_W'(K));
  // The first WAIT cycle may still see the previous request's finish flag.
  assign w_capture  = (r_state == WAIT) && !r_wait_first && mem_finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_img_w      <= '0;
      r_img_h      <= '0;
      r_stride     <= '0;
      r_err        <= 1'b0;
      r_wait_first <= 1'b0;
      r_win_data   <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && start) begin
        r_base   <= base_addr;
        r_img_w  <= img_w;
        r_img_h  <= img_h;
        r_stride <= (stride == '0) ? DIM_W'(1) : stride;
        r_err    <= 1'b0;
      end
      if ((r_state == INIT) && w_dims_bad) begin
        r_err <= 1'b1;
      end
      r_wait_first <= (r_state == REQ);
      if (w_capture) begin
        r_win_data <= mem_data;
        r_win_row  <= w_row;
        r_win_col  <= w_col;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_init       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_next = INIT;
      INIT: begin
        if (w_dims_bad) begin
          w_state_next = DONE;
        end else begin
          w_init       = 1'b1;
          w_state_next = GAP;
        end
      end
      GAP:     w_state_next = REQ;
      REQ:     w_state_next = WAIT;
      WAIT:    if (w_capture) w_state_next = PRESENT;
      PRESENT: begin
        if (win_ready) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? DONE : GAP;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign mem_enable  = (r_state == REQ) || (r_state == WAIT);
  assign mem_write   = 1'b0;
  assign mem_address = w_addr;
  assign mem_offset  = ADDR_W'(r_img_w);
  assign win_valid   = (r_state == PRESENT);
  assign win_data    = r_win_data;
  assign win_row     = r_win_row;
  assign win_col     = r_win_col;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign err         = r_err;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch with a behavioural 5x5 window memory
// (2-cycle finish, registered data, optional stale finish flag).
module tb_conv_window_fetch;

  localparam int K      = 5;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DIM_W  = 16;
  localparam int WIN_W  = K*K*DATA_W;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DIM_W-1:0]  img_w = '0;
  logic [DIM_W-1:0]  img_h = '0;
  logic [DIM_W-1:0]  stride = '0;
  logic              mem_enable;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [ADDR_W-1:0] mem_offset;
  logic              mem_finish = 1'b0;
  logic [WIN_W-1:0]  mem_data = '0;
  logic              win_valid;
  logic              win_ready = 1'b1;
  logic [WIN_W-1:0]  win_data;
  logic [DIM_W-1:0]  win_row;
  logic [DIM_W-1:0]  win_col;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  logic stale_mode = 1'b0;
  logic en_prev = 1'b0;
  logic m_en_d = 1'b0;
  int   m_cnt = 0;
  logic [ADDR_W-1:0] req_addr_q[$];
  logic [ADDR_W-1:0] req_off_q[$];

  conv_window_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .img_w       (img_w),
    .img_h       (img_h),
    .stride      (stride),
    .mem_enable  (mem_enable),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_offset  (mem_offset),
    .mem_finish  (mem_finish),
    .mem_data    (mem_data),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIN_W-1:0] mk_win(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] off);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DATA_W +: DATA_W] = DATA_W'(a + ADDR_W'(r) * off + ADDR_W'(c));
    return v;
  endfunction

  // Memory model: finish re-arms on an enable rising edge; in stale mode the
  // old finish lingers one extra cycle into WAIT with old data.
  always @(posedge clk) begin
    if (rst) begin
      mem_finish <= 1'b0;
      m_cnt      <= 0;
    end else if (mem_enable && !m_en_d) begin
      if (!stale_mode) mem_finish <= 1'b0;
      m_cnt <= MEM_LAT;
    end else if (mem_enable && m_cnt != 0) begin
      mem_finish <= (m_cnt == 1);
      if (m_cnt == 1) mem_data <= mk_win(mem_address, mem_offset);
      m_cnt <= m_cnt - 1;
    end
    m_en_d <= rst ? 1'b0 : mem_enable;
  end

  always @(negedge clk) begin
    if (mem_enable && !en_prev) begin
      req_addr_q.push_back(mem_address);
      req_off_q.push_back(mem_offset);
    end
    en_prev = mem_enable;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic pulse_start(input int base, input int w, input int h, input int s);
    @(negedge clk);
    base_addr = ADDR_W'(base);
    img_w     = DIM_W'(w);
    img_h     = DIM_W'(h);
    stride    = DIM_W'(s);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_map(input int base, input int w, input int h, input int s, input int bp_idx);
    int ss, ow, oh, n, r, c, t, d0;
    logic [ADDR_W-1:0] ea;
    logic [WIN_W-1:0] held;
    ss = (s == 0) ? 1 : s;
    ow = (w - K) / ss + 1;
    oh = (h - K) / ss + 1;
    n  = ow * oh;
    req_addr_q.delete();
    req_off_q.delete();
    d0 = done_cnt;
    pulse_start(base, w, h, s);
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    for (int i = 0; i < n; i++) begin
      r  = i / ow;
      c  = i % ow;
      ea = ADDR_W'(base + r*w*ss + c*ss);
      win_ready = (i == bp_idx) ? 1'b0 : 1'b1;
      t = 0;
      while (!win_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!win_valid) begin
        check("win_valid_timeout", 0, 1);
        win_ready = 1'b1;
        return;
      end
      check("win_row", win_row, r);
      check("win_col", win_col, c);
      check("win_word00", win_data[DATA_W-1:0], ea);
      check("win_full_match", win_data == mk_win(ea, ADDR_W'(w)), 1);
      if (i == bp_idx) begin
        held = win_data;
        for (int k = 0; k < 4; k++) begin
          // A start while busy must leave the latched parameters alone.
          if (k == 0) begin
            start = 1'b1;
            base_addr = 16'h03e7;
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
          check("bp_valid_held", win_valid, 1);
          check("bp_data_stable", win_data == held, 1);
          check("bp_col_stable", win_col, c);
          check("bp_no_request", mem_enable, 0);
        end
        start = 1'b0;
        win_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_low", done, 0);
    check("busy_low", busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("req_count", req_addr_q.size(), n);
    for (int i = 0; i < n && i < req_addr_q.size(); i++) begin
      r  = i / ow;
      c  = i % ow;
      ea = ADDR_W'(base + r*w*ss + c*ss);
      check("req_addr", req_addr_q[i], ea);
      check("req_offset", req_off_q[i], w);
    end
  endtask

  initial begin
    int t, d0;
    logic seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_win_valid", win_valid, 0);

    // 5x5 minimal map, then 7x6 with a stale finish flag.
    run_map(100, 5, 5, 1, -1);
    stale_mode = 1'b1;
    run_map(0, 7, 6, 1, -1);
    stale_mode = 1'b0;
    // 9x9 stride 2 with backpressure on the second window.
    run_map(10, 9, 9, 2, 1);

    // Too-narrow image: err and done without any memory request.
    req_addr_q.delete();
    d0 = done_cnt;
    pulse_start(0, 4, 9, 1);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("err_done_seen", seen, 1);
    check("err_set", err, 1);
    @(negedge clk);
    check("err_sticky", err, 1);
    check("err_busy_low", busy, 0);
    check("err_done_count", done_cnt - d0, 1);
    check("err_no_request", req_addr_q.size(), 0);

    // Valid start clears err; stride 0 behaves as stride 1.
    run_map(0, 7, 6, 0, -1);

    // Reset while waiting on the memory.
    d0 = done_cnt;
    pulse_start(0, 7, 6, 1);
    t = 0;
    while (!mem_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rw_enable_seen", mem_enable, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_mem_enable", mem_enable, 0);
    check("rw_busy", busy, 0);
    check("rw_win_valid", win_valid, 0);
    repeat (3) @(negedge clk);
    check("rw_no_done", done_cnt - d0, 0);
    run_map(0, 7, 6, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Upstream controller for the 5x5 window-read memory.
- Walks a feature map stored row-major in that memory and issues one window read per output position (address, row stride, enable).
- Waits for the memory's finish flag, captures the 25-word window, and presents it to the convolution MAC stage over a valid/ready handshake.
- One instance per conv layer pass, started by the layer controller.

Parameters:
- K, 5, window edge in words; fixed to match the memory's 5x5 read port.
- ADDR_W, 16, address width in words.
- DATA_W, 16, signed data word width.
- DIM_W, 16, width of the image dimension and stride inputs.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  word address of pixel (0,0).
- img_w  in  DIM_W  image width in words; also the memory row offset.
- img_h  in  DIM_W  image height in rows.
- stride  in  DIM_W  window step in both directions; 0 is treated as 1.
- mem_enable  out  1  read request level to the memory.
- mem_write  out  1  constant 0.
- mem_address  out  ADDR_W  top-left word of the current window.
- mem_offset  out  ADDR_W  equals img_w.
- mem_finish  in  1  memory completion flag.
- mem_data  in  K*K*DATA_W  window words; row r, column c occupies bits [(r*K+c)*DATA_W +: DATA_W].
- win_valid  out  1  captured window available.
- win_ready  in  1  consumer accepts.
- win_data  out  K*K*DATA_W  registered window.
- win_row, win_col  out  DIM_W  output-map coordinates of win_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.
- err  out  1  sticky until the next start; set when img_w<K or img_h<K.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and counters are cleared. Reset mid-operation aborts immediately; there is no done pulse and the memory enable drops the next cycle.
- Output map size:
  - OW = (img_w-K)/stride + 1, computed with integer divide.
  - OH = (img_h-K)/stride + 1.
  - Both are computed once in INIT and latched.
- States:
  - IDLE: on start, latch inputs and go to INIT.
  - INIT:
    - If img_w<K or img_h<K, set err, pulse done, and return to IDLE.
    - Otherwise row=col=0, row_base=base_addr, and go to GAP.
  - GAP: mem_enable=0 for exactly one cycle. The memory re-arms finish only on an enable rising edge, so every request must be preceded by a low cycle. Then go to REQ.
  - REQ:
    - mem_enable=1, mem_address=row_base+col*stride, mem_offset=img_w.
    - Go to WAIT.
  - WAIT:
    - Hold mem_enable=1 with address stable.
    - A mem_finish seen in the first WAIT cycle is ignored as stale.
    - Thereafter, on mem_finish=1, capture mem_data into win_data, latch win_row/win_col, and go to PRESENT. mem_enable drops in that same cycle.
  - PRESENT:
    - win_valid=1; win_data, win_row and win_col are held stable until win_ready.
    - On the valid&ready cycle, advance the counters: col++; if col==OW-1, then col=0, row++ and row_base+=img_w*stride.
    - If the accepted window was (OH-1, OW-1), go to DONE; else go to GAP.
  - DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.
- Minimum cost per window is GAP + REQ + WAIT(>=2) + PRESENT(>=1), i.e. 5 cycles with an immediate finish and ready.
- win_ready asserted while win_valid=0 has no effect.
- start while busy is ignored, and the latched parameters are not disturbed.

Decomposition:
- Shared package cnn_pkg:
  - K, DATA_W, ADDR_W.
  - window_t, a packed K*K*DATA_W array.
  - fetch_state_e enum: IDLE, INIT, GAP, REQ, WAIT, PRESENT, DONE.
- One natural sub-module, conv_pos_counter: holds row/col/row_base, supplies OW/OH-based last-position detection, and takes an advance strobe.
- The FSM and capture register live in the top.

Test Plan:
- Minimal map: base=100, img_w=img_h=5, stride=1, memory model with 2-cycle finish, ready always high.
  - Exactly one request at address 100 with offset 5.
  - One window at (0,0); done pulses once.
- 7x6 map, stride 1, base 0:
  - OW=3, OH=2, 6 windows.
  - Addresses 0,1,2,7,8,9 in order, each request preceded by a cycle with mem_enable=0.
- Stride 2 on a 9x9 map, base 10:
  - OW=OH=3.
  - Addresses 10,12,14,28,30,32,46,48,50.
- Backpressure: hold win_ready low for 4 cycles on the second window.
  - win_valid, win_data and win_col=1 are stable throughout.
  - No new memory request until acceptance.
- Error: img_w=4.
  - err=1 and done pulses within 3 cycles of start; mem_enable is never asserted.
  - A following valid start clears err.
- Reset in WAIT:
  - mem_enable=0, busy=0 and win_valid=0 the cycle after rst.
  - A subsequent start restarts from (0,0).
